// File: rtl/layer_priority_mux.sv
// Priority compositor for a stack of graphic layers with colour-key transparency,
// per-layer blinking and a per-frame overlap flag. Layer 0 is the top layer.
module layer_priority_mux #(
    parameter int unsigned NUM_LAYERS   = 4,
    parameter int unsigned RGB_W        = 8,
    parameter logic [RGB_W-1:0] TRANSPARENT = 8'hFF,
    parameter int unsigned BLINK_FRAMES = 16
) (
    input  logic                        clk,
    input  logic                        resetN,
    input  logic                        startOfFrame,
    input  logic [NUM_LAYERS-1:0]       layers_DR,
    input  logic [NUM_LAYERS*RGB_W-1:0] layers_RGB,
    input  logic [NUM_LAYERS-1:0]       layer_en,
    input  logic [NUM_LAYERS-1:0]       blink_mask,
    input  logic [RGB_W-1:0]            bg_RGB,
    output logic                        out_DR,
    output logic [RGB_W-1:0]            out_RGB,
    output logic [2:0]                  out_layer,
    output logic                        blink_phase,
    output logic                        frame_overlap
);

    localparam logic [7:0] LastFrame = 8'(BLINK_FRAMES - 1);

    logic [NUM_LAYERS-1:0] eligible;
    logic                  win_valid;
    logic [2:0]            win_idx;
    logic [RGB_W-1:0]      win_rgb;
    logic                  overlap_now;
    logic [7:0]            frame_cnt;
    logic                  overlap_acc;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            eligible[i] = layers_DR[i] && layer_en[i]
                       && (layers_RGB[i*RGB_W +: RGB_W] != TRANSPARENT)
                       && !(blink_mask[i] && blink_phase);
        end
    end

    // Scan from the bottom up so the lowest eligible index is the last to win.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        win_rgb   = bg_RGB;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_valid = 1'b1;
                win_idx   = 3'(i);
                win_rgb   = layers_RGB[i*RGB_W +: RGB_W];
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign overlap_now = |(eligible & (eligible - {{(NUM_LAYERS-1){1'b0}}, 1'b1}));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            out_DR    <= 1'b0;
            out_RGB   <= '0;
            out_layer <= '0;
        end else begin
            out_DR    <= win_valid;
            out_RGB   <= win_rgb;
            out_layer <= win_idx;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (startOfFrame) begin
            if (frame_cnt == LastFrame) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    // The overlap seen on the startOfFrame cycle belongs to the frame that is ending.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            overlap_acc   <= 1'b0;
            frame_overlap <= 1'b0;
        end else if (startOfFrame) begin
            frame_overlap <= overlap_acc | overlap_now;
            overlap_acc   <= 1'b0;
        end else begin
            overlap_acc <= overlap_acc | overlap_now;
        end
    end

endmodule

// File: tb/tb_layer_priority_mux.sv
// Directed bench for layer_priority_mux: priority, transparency, blinking, overlap, reset.
module tb_layer_priority_mux;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic [3:0]  layers_DR;
    logic [31:0] layers_RGB;
    logic [3:0]  layer_en;
    logic [3:0]  blink_mask;
    logic [7:0]  bg_RGB;
    logic        out_DR;
    logic [7:0]  out_RGB;
    logic [2:0]  out_layer;
    logic        blink_phase;
    logic        frame_overlap;

    int n_checks = 0;
    int n_fail   = 0;

    layer_priority_mux #(
        .NUM_LAYERS  (4),
        .RGB_W       (8),
        .TRANSPARENT (8'hFF),
        .BLINK_FRAMES(2)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .layers_DR    (layers_DR),
        .layers_RGB   (layers_RGB),
        .layer_en     (layer_en),
        .blink_mask   (blink_mask),
        .bg_RGB       (bg_RGB),
        .out_DR       (out_DR),
        .out_RGB      (out_RGB),
        .out_layer    (out_layer),
        .blink_phase  (blink_phase),
        .frame_overlap(frame_overlap)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and land 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        startOfFrame = 1'b0;
        layers_DR    = 4'b0000;
        layers_RGB   = 32'h0;
        layer_en     = 4'b1111;
        blink_mask   = 4'b0000;
        bg_RGB       = 8'h49;
    endtask

    task automatic pulse_reset();
        idle_inputs();
        resetN = 1'b0;
        #3;
        resetN = 1'b1;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        layers_DR  = 4'b0001;
        layers_RGB = 32'h0000_0077;
        resetN     = 1'b0;
        step();
        step();
        n_checks++; if (out_DR !== 1'b0) begin n_fail++; $display("FAIL reset_dr got %b want 0", out_DR); end
        n_checks++; if (out_RGB !== 8'h00) begin n_fail++; $display("FAIL reset_rgb got %h want 00", out_RGB); end
        n_checks++; if (out_layer !== 3'd0) begin n_fail++; $display("FAIL reset_layer got %0d want 0", out_layer); end
        n_checks++; if (blink_phase !== 1'b0) begin n_fail++; $display("FAIL reset_phase got %b want 0", blink_phase); end
        n_checks++; if (frame_overlap !== 1'b0) begin n_fail++; $display("FAIL reset_overlap got %b want 0", frame_overlap); end
        resetN = 1'b1;
        step();
        n_checks++; if (out_RGB !== 8'h77) begin n_fail++; $display("FAIL reset_release_rgb got %h want 77", out_RGB); end
    endtask

    task automatic test_priority();
        pulse_reset();
        layers_DR  = 4'b0110;
        layers_RGB = {8'h00, 8'hE0, 8'h1C, 8'h00};
        step();
        n_checks++; if (out_RGB !== 8'h1C) begin n_fail++; $display("FAIL prio_rgb got %h want 1c", out_RGB); end
        n_checks++; if (out_layer !== 3'd1) begin n_fail++; $display("FAIL prio_layer got %0d want 1", out_layer); end
        n_checks++; if (out_DR !== 1'b1) begin n_fail++; $display("FAIL prio_dr got %b want 1", out_DR); end
        layers_DR  = 4'b1000;
        layers_RGB = {8'h55, 8'hE0, 8'h1C, 8'h00};
        step();
        n_checks++; if (out_layer !== 3'd3 || out_RGB !== 8'h55) begin
            n_fail++; $display("FAIL prio_l3 got %0d/%h want 3/55", out_layer, out_RGB); end
    endtask

    task automatic test_transparent();
        pulse_reset();
        layers_DR  = 4'b0011;
        layers_RGB = {8'h00, 8'h00, 8'h03, 8'hFF};
        step();
        n_checks++; if (out_RGB !== 8'h03) begin n_fail++; $display("FAIL transp_rgb got %h want 03", out_RGB); end
        n_checks++; if (out_layer !== 3'd1) begin n_fail++; $display("FAIL transp_layer got %0d want 1", out_layer); end
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        n_checks++; if (frame_overlap !== 1'b0) begin n_fail++; $display("FAIL transp_overlap got %b want 0", frame_overlap); end
    endtask

    task automatic test_blink();
        logic [3:0] want_phase;
        want_phase = 4'b0110;  // phase after pulses 1..4, bit index = pulse-1
        pulse_reset();
        blink_mask = 4'b0001;
        layers_DR  = 4'b0001;
        layers_RGB = 32'h0000_002A;
        for (int p = 0; p < 4; p++) begin
            // Pixel on the pulse cycle uses the phase from before the pulse.
            startOfFrame = 1'b1;
            step();
            startOfFrame = 1'b0;
            n_checks++; if (out_DR !== (p < 2)) begin
                n_fail++; $display("FAIL blink_pulse_dr p%0d got %b want %b", p + 1, out_DR, (p < 2)); end
            n_checks++; if (blink_phase !== want_phase[p]) begin
                n_fail++; $display("FAIL blink_phase p%0d got %b want %b", p + 1, blink_phase, want_phase[p]); end
            step();
            n_checks++; if (out_RGB !== (want_phase[p] ? 8'h49 : 8'h2A)) begin
                n_fail++; $display("FAIL blink_rgb p%0d got %h want %h", p + 1, out_RGB,
                                   (want_phase[p] ? 8'h49 : 8'h2A)); end
        end
    endtask

    task automatic test_overlap();
        pulse_reset();
        layers_DR  = 4'b1001;
        layers_RGB = {8'h33, 8'h00, 8'h00, 8'h11};
        step();
        n_checks++; if (out_RGB !== 8'h11 || frame_overlap !== 1'b0) begin
            n_fail++; $display("FAIL ovl_mid got %h/%b want 11/0", out_RGB, frame_overlap); end
        layers_DR    = 4'b0000;
        startOfFrame = 1'b1;
        step();
        n_checks++; if (frame_overlap !== 1'b1) begin n_fail++; $display("FAIL ovl_set got %b want 1", frame_overlap); end
        startOfFrame = 1'b0;
        layers_DR    = 4'b0001;
        step();
        step();
        n_checks++; if (frame_overlap !== 1'b1) begin n_fail++; $display("FAIL ovl_hold got %b want 1", frame_overlap); end
        startOfFrame = 1'b1;
        step();
        n_checks++; if (frame_overlap !== 1'b0) begin n_fail++; $display("FAIL ovl_clean got %b want 0", frame_overlap); end
        // Overlap on the pulse cycle itself closes out the ending frame.
        layers_DR = 4'b1001;
        step();
        n_checks++; if (frame_overlap !== 1'b1) begin n_fail++; $display("FAIL ovl_sof_cycle got %b want 1", frame_overlap); end
        layers_DR = 4'b0000;
        step();
        n_checks++; if (frame_overlap !== 1'b0) begin n_fail++; $display("FAIL ovl_cleared got %b want 0", frame_overlap); end
        startOfFrame = 1'b0;
    endtask

    task automatic test_enable();
        pulse_reset();
        layer_en   = 4'b0000;
        layers_DR  = 4'b1111;
        layers_RGB = {8'h44, 8'h33, 8'h22, 8'h11};
        step();
        n_checks++; if (out_RGB !== 8'h49 || out_DR !== 1'b0 || out_layer !== 3'd0) begin
            n_fail++; $display("FAIL en_off got %h/%b/%0d want 49/0/0", out_RGB, out_DR, out_layer); end
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        n_checks++; if (frame_overlap !== 1'b0) begin n_fail++; $display("FAIL en_overlap got %b want 0", frame_overlap); end
        layer_en = 4'b0100;
        step();
        n_checks++; if (out_RGB !== 8'h33 || out_layer !== 3'd2) begin
            n_fail++; $display("FAIL en_one got %h/%0d want 33/2", out_RGB, out_layer); end
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        layers_DR  = 4'b0011;
        layers_RGB = {8'h00, 8'h00, 8'h22, 8'h11};
        startOfFrame = 1'b1;
        step();
        step();
        step();  // counter 1, phase 1, overlap accumulating
        startOfFrame = 1'b0;
        step();
        n_checks++; if (blink_phase !== 1'b1 || out_DR !== 1'b1) begin
            n_fail++; $display("FAIL mid_pre got %b/%b want 1/1", blink_phase, out_DR); end
        resetN = 1'b0;
        #2;
        n_checks++; if ({out_DR, out_RGB, out_layer, blink_phase, frame_overlap} !== 13'd0) begin
            n_fail++; $display("FAIL mid_async got %b/%h/%0d/%b/%b want all 0",
                               out_DR, out_RGB, out_layer, blink_phase, frame_overlap); end
        resetN     = 1'b1;
        layers_DR  = 4'b0100;
        layers_RGB = {8'h00, 8'h5A, 8'h00, 8'h00};
        step();
        n_checks++; if (out_RGB !== 8'h5A || out_layer !== 3'd2 || out_DR !== 1'b1) begin
            n_fail++; $display("FAIL mid_resume got %h/%0d/%b want 5a/2/1", out_RGB, out_layer, out_DR); end
        startOfFrame = 1'b1;
        step();
        n_checks++; if (blink_phase !== 1'b0 || frame_overlap !== 1'b0) begin
            n_fail++; $display("FAIL mid_frame1 got %b/%b want 0/0", blink_phase, frame_overlap); end
        step();
        startOfFrame = 1'b0;
        n_checks++; if (blink_phase !== 1'b1) begin n_fail++; $display("FAIL mid_frame2 got %b want 1", blink_phase); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  v_dr  [4];
        logic [31:0] v_rgb [4];
        logic [7:0]  e_rgb [4];
        logic [2:0]  e_lay [4];
        logic        e_dr  [4];
        v_dr = '{4'b0001, 4'b1110, 4'b0100, 4'b1000};
        v_rgb = '{32'h0000_0001, 32'h4433_2211, 32'h00FF_0000, 32'h6600_0000};
        e_rgb = '{8'h01, 8'h22, 8'h49, 8'h66};
        e_lay = '{3'd0, 3'd1, 3'd0, 3'd3};
        e_dr  = '{1'b1, 1'b1, 1'b0, 1'b1};
        pulse_reset();
        for (int k = 0; k < 4; k++) begin
            layers_DR  = v_dr[k];
            layers_RGB = v_rgb[k];
            step();
            n_checks++; if (out_RGB !== e_rgb[k] || out_layer !== e_lay[k] || out_DR !== e_dr[k]) begin
                n_fail++; $display("FAIL b2b_%0d got %h/%0d/%b want %h/%0d/%b", k, out_RGB, out_layer,
                                   out_DR, e_rgb[k], e_lay[k], e_dr[k]); end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_priority();
        test_transparent();
        test_blink();
        test_overlap();
        test_enable();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_priority_mux.md
LAYER_PRIORITY_MUX -- requirements
Module: layer_priority_mux

Interface
REQ-001 Parameter NUM_LAYERS, default 4, number of graphic layers (legal 2..8); layer 0 has highest priority.
REQ-002 Parameter RGB_W, default 8, colour width per layer.
REQ-003 Parameter TRANSPARENT, default 8'hFF, colour key treated as "not drawing".
REQ-004 Parameter BLINK_FRAMES, default 16, frames per blink half-period (legal 1..255).
REQ-005 clk  input  1  pixel clock; single clock domain.
REQ-006 resetN  input  1  asynchronous, active-low reset.
REQ-007 startOfFrame  input  1  one-cycle pulse at frame start.
REQ-008 layers_DR  input  NUM_LAYERS  per-layer draw request; bit i belongs to layer i.
REQ-009 layers_RGB  input  NUM_LAYERS*RGB_W  packed colours; layer i occupies bits [i*RGB_W +: RGB_W].
REQ-010 layer_en  input  NUM_LAYERS  static per-layer enable; 0 masks the layer.
REQ-011 blink_mask  input  NUM_LAYERS  layers subject to blinking.
REQ-012 bg_RGB  input  RGB_W  background colour.
REQ-013 out_DR  output  1  registered: some layer won.
REQ-014 out_RGB  output  RGB_W  registered final pixel colour.
REQ-015 out_layer  output  3  registered index of winning layer (0 when none).
REQ-016 blink_phase  output  1  current blink phase.
REQ-017 frame_overlap  output  1  previous frame contained at least one overlapping pixel.

Function
REQ-018 Layer i is eligible when layers_DR[i]=1, layer_en[i]=1, its colour differs from TRANSPARENT, and not (blink_mask[i]=1 and blink_phase=1).
REQ-019 Winner is the lowest-index eligible layer; out_RGB <= its colour, out_DR <= 1, out_layer <= its index, on the next rising clk edge (latency 1 cycle).
REQ-020 No eligible layer: out_RGB <= bg_RGB, out_DR <= 0, out_layer <= 0, next edge.
REQ-021 Frame counter, width 8, increments on each startOfFrame and wraps from BLINK_FRAMES-1 to 0; blink_phase toggles on that wrap edge.
REQ-022 BLINK_FRAMES=1: blink_phase toggles on every startOfFrame.
REQ-023 startOfFrame concurrent with pixel data: the pixel uses the pre-update blink_phase; new phase affects the following cycle onward.
REQ-024 Overlap accumulator sets when two or more layers are eligible in the same cycle; it is sticky within a frame.
REQ-025 On startOfFrame: frame_overlap <= accumulator OR current-cycle overlap; accumulator clears (current-cycle overlap counts toward the ended frame).
REQ-026 Inputs are unregistered; the module adds no other delay and applies no handshake (pixel stream, every cycle valid).
REQ-027 Changing layer_en or blink_mask takes effect on the next edge without glitching out_* registers.

Reset
REQ-028 resetN=0 asynchronously forces out_DR=0, out_RGB=0, out_layer=0, blink_phase=0, frame_overlap=0, frame counter=0, accumulator=0.
REQ-029 Reset mid-frame discards accumulated overlap and blink progress; after release, the first startOfFrame counts as frame 1.
REQ-030 Outputs resume normal 1-cycle behaviour on the first edge after resetN rises.

Verification
REQ-031 NUM_LAYERS=4, layers_DR=4'b0110, RGB1=8'h1C, RGB2=8'hE0, all enabled -> next cycle out_RGB=8'h1C, out_layer=1, out_DR=1.
REQ-032 layers_DR=4'b0011, RGB0=8'hFF (transparent), RGB1=8'h03 -> out_RGB=8'h03, out_layer=1; next frame frame_overlap=0.
REQ-033 blink_mask=4'b0001, layer 0 only drawing, BLINK_FRAMES=2, four startOfFrame pulses -> blink_phase 0,1,1,0 toggling after pulses 2 and 4; layer 0 suppressed (out_RGB=bg_RGB, out_DR=0) while phase=1.
REQ-034 Layers 0 and 3 eligible in one cycle mid-frame, then startOfFrame -> frame_overlap=1 for the next frame, returns 0 after a clean frame.
REQ-035 Assert resetN=0 during phase=1 with counter=1 -> all outputs 0 immediately (no clock); after release, out_* track inputs with 1-cycle latency.
REQ-036 layer_en=4'b0000 with all layers drawing, bg_RGB=8'h49 -> out_RGB=8'h49, out_DR=0, no overlap recorded.
